// File: rtl/bus_mux_n.sv
// N-slave bus interconnect: decodes the master address against a base/mask map,
// strobes one slave, and returns its data/ack, or a bus error on a miss or timeout.
module bus_mux_n #(
   parameter int                        N_SLAVES   = 4,
   parameter int                        ADDR_W     = 32,
   parameter int                        DATA_W     = 16,
   parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
   parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0,
   parameter int                        TIMEOUT    = 255
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [ADDR_W-1:0]            master_addr,
   input  logic [DATA_W-1:0]            master_write,
   input  logic [1:0]                   master_be,
   input  logic                         master_rw,
   input  logic                         master_ds,
   output logic [DATA_W-1:0]            master_read,
   output logic                         master_ack,
   output logic                         master_err,
   output logic [ADDR_W-1:0]            err_addr,
   output logic [ADDR_W-1:0]            slave_addr,
   output logic [DATA_W-1:0]            slave_write,
   output logic [1:0]                   slave_be,
   output logic                         slave_rw,
   output logic [N_SLAVES-1:0]          slave_ds,
   input  logic [N_SLAVES*DATA_W-1:0]   slave_read,
   input  logic [N_SLAVES-1:0]          slave_ack
);

   localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
   localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT == 0) ? '0 : TMR_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t               state, state_nxt;
   logic [SEL_W-1:0]     sel, sel_d;
   logic [TMR_W-1:0]     timer, timer_d;

   logic                 hit;
   logic [SEL_W-1:0]     hit_idx;
   logic                 sel_ack;
   logic [DATA_W-1:0]    sel_read;
   logic                 timeout_hit;

   logic [N_SLAVES-1:0]  ds_d;
   logic                 ack_d, err_d, latch_en;
   logic [ADDR_W-1:0]    err_addr_d;
   logic [DATA_W-1:0]    read_d;

   // Scan from the top down so the lowest matching slot is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = N_SLAVES - 1; i >= 0; i--) begin
         if ((master_addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
            hit     = 1'b1;
            hit_idx = SEL_W'(i);
         end
      end
   end

   assign sel_ack     = slave_ack[sel];
   assign sel_read    = slave_read[sel*DATA_W +: DATA_W];
   assign timeout_hit = (TIMEOUT != 0) && (timer == TMR_LAST);

   always_ff @(posedge clk) begin
      // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (master_ds) state_nxt = hit ? ACCESS : DONE;
         ACCESS: begin
            if (!master_ds)                 state_nxt = IDLE;
            else if (sel_ack || timeout_hit) state_nxt = DONE;
         end
         DONE:    if (!master_ds) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Abort outranks completion; within a live access an ack outranks the timeout.
   always_comb begin
      // NOTE: each target starts from its held value, so no branch can leave one unassigned and infer a latch.
      ds_d       = slave_ds;
      ack_d      = master_ack;
      err_d      = master_err;
      err_addr_d = err_addr;
      read_d     = master_read;
      sel_d      = sel;
      timer_d    = timer;
      latch_en   = 1'b0;
      unique case (state)
         IDLE: begin
            if (master_ds) begin
               if (hit) begin
                  latch_en      = 1'b1;
                  sel_d         = hit_idx;
                  timer_d       = '0;
                  ds_d          = '0;
                  ds_d[hit_idx] = 1'b1;
               end else begin
                  err_d      = 1'b1;
                  err_addr_d = master_addr;
               end
            end
         end
         ACCESS: begin
            if (!master_ds) begin
               ds_d = '0;
            end else if (sel_ack) begin
               ds_d  = '0;
               ack_d = 1'b1;
               if (slave_rw) read_d = sel_read;
            end else if (timeout_hit) begin
               ds_d       = '0;
               err_d      = 1'b1;
               err_addr_d = slave_addr;
            end else if (timer != '1) begin
               timer_d = timer + TMR_W'(1);
            end
         end
         DONE: begin
            if (!master_ds) begin
               ack_d = 1'b0;
               err_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: reset clears the data latches too, so every output reads zero out of reset.
      if (!reset_n) begin
         slave_ds    <= '0;
         master_ack  <= 1'b0;
         master_err  <= 1'b0;
         err_addr    <= '0;
         master_read <= '0;
         sel         <= '0;
         timer       <= '0;
         slave_addr  <= '0;
         slave_write <= '0;
         slave_be    <= '0;
         slave_rw    <= 1'b0;
      end else begin
         slave_ds    <= ds_d;
         master_ack  <= ack_d;
         master_err  <= err_d;
         err_addr    <= err_addr_d;
         master_read <= read_d;
         sel         <= sel_d;
         timer       <= timer_d;
         if (latch_en) begin
            slave_addr  <= master_addr;
            slave_write <= master_write;
            slave_be    <= master_be;
            slave_rw    <= master_rw;
         end
      end
   end

endmodule

// File: tb/tb_bus_mux_n.sv
// Self-checking bench for bus_mux_n: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_bus_mux_n;

   localparam int N   = 4;
   localparam int AW  = 32;
   localparam int DW  = 16;
   localparam int TMO = 8;
   localparam logic [N*AW-1:0] BASE = {32'h00F1_0000, 32'h00F1_0000, 32'h00F0_0000, 32'h0000_0000};
   localparam logic [N*AW-1:0] MASK = {32'hFFFF_0000, 32'hFFFF_FF00, 32'hFFFF_0000, 32'hFFF0_0000};

   logic [31:0] m_base [N] = '{32'h0000_0000, 32'h00F0_0000, 32'h00F1_0000, 32'h00F1_0000};
   logic [31:0] m_mask [N] = '{32'hFFF0_0000, 32'hFFFF_0000, 32'hFFFF_FF00, 32'hFFFF_0000};

   logic            clk, reset_n;
   logic [AW-1:0]   master_addr;
   logic [DW-1:0]   master_write;
   logic [1:0]      master_be;
   logic            master_rw, master_ds;
   logic [DW-1:0]   master_read;
   logic            master_ack, master_err;
   logic [AW-1:0]   err_addr, slave_addr;
   logic [DW-1:0]   slave_write;
   logic [1:0]      slave_be;
   logic            slave_rw;
   logic [N-1:0]    slave_ds;
   logic [N*DW-1:0] slave_read;
   logic [N-1:0]    slave_ack;
   logic [DW-1:0]   sread [N];

   assign slave_read = {sread[3], sread[2], sread[1], sread[0]};

   bus_mux_n #(
      .N_SLAVES(N), .ADDR_W(AW), .DATA_W(DW),
      .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .master_addr(master_addr), .master_write(master_write), .master_be(master_be),
      .master_rw(master_rw), .master_ds(master_ds),
      .master_read(master_read), .master_ack(master_ack), .master_err(master_err),
      .err_addr(err_addr),
      .slave_addr(slave_addr), .slave_write(slave_write), .slave_be(slave_be),
      .slave_rw(slave_rw), .slave_ds(slave_ds),
      .slave_read(slave_read), .slave_ack(slave_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: who currently owns the bus and how long its strobe has been up.
   logic [DW-1:0] m_read;
   logic          m_ack, m_err, m_srw;
   logic [AW-1:0] m_err_addr, m_saddr;
   logic [DW-1:0] m_swrite;
   logic [1:0]    m_sbe;
   int            m_owner = -1;
   int            m_hi    = 0;
   bit            m_live  = 1'b0;

   function automatic int decode(input logic [31:0] a);
      for (int i = 0; i < N; i++)
         if ((a & m_mask[i]) == m_base[i]) return i;
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_ds();
      logic [N-1:0] v = '0;
      if (m_owner >= 0) v[m_owner] = 1'b1;
      return v;
   endfunction

   always @(posedge clk) begin
      int hit;
      if (!reset_n) begin
         m_read = '0; m_ack = 0; m_err = 0; m_err_addr = '0;
         m_saddr = '0; m_swrite = '0; m_sbe = '0; m_srw = 0;
         m_owner = -1; m_hi = 0; m_live = 1'b1;
      end else if (m_ack || m_err) begin
         if (!master_ds) begin m_ack = 0; m_err = 0; end
      end else if (m_owner >= 0) begin
         if (!master_ds) begin
            m_owner = -1;
         end else if (slave_ack[m_owner]) begin
            if (m_srw) m_read = sread[m_owner];
            m_ack   = 1;
            m_owner = -1;
         end else begin
            m_hi++;
            if (m_hi == TMO) begin
               m_err = 1; m_err_addr = m_saddr; m_owner = -1;
            end
         end
      end else if (master_ds) begin
         hit = decode(master_addr);
         if (hit >= 0) begin
            m_owner = hit; m_hi = 0;
            m_saddr = master_addr; m_swrite = master_write; m_sbe = master_be; m_srw = master_rw;
         end else begin
            m_err = 1; m_err_addr = master_addr;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (m_live) begin
         check("slave_ds",    slave_ds,    exp_ds());
         check("master_ack",  master_ack,  m_ack);
         check("master_err",  master_err,  m_err);
         check("master_read", master_read, m_read);
         check("err_addr",    err_addr,    m_err_addr);
         check("slave_addr",  slave_addr,  m_saddr);
         check("slave_write", slave_write, m_swrite);
         check("slave_be",    slave_be,    m_sbe);
         check("slave_rw",    slave_rw,    m_srw);
         check("ds_onehot0",  $onehot0(slave_ds), 1);
         check("ack_err_excl", master_ack & master_err, 0);
      end
   end

   task automatic start(input logic [31:0] a, input logic rw, input logic [15:0] d, input logic [1:0] be);
      master_addr  = a;
      master_rw    = rw;
      master_write = d;
      master_be    = be;
      master_ds    = 1'b1;
   endtask

   function automatic logic [31:0] rand_addr();
      int k = $urandom_range(0, 4);
      if (k == 4) return $urandom();
      return (m_base[k] & m_mask[k]) | ($urandom() & ~m_mask[k]);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, expected completion before %0t", $time);
      $fatal(1);
   end

   initial begin
      int cnt;
      bit active;
      reset_n = 0; master_addr = '0; master_write = '0; master_be = '0;
      master_rw = 0; master_ds = 0; slave_ack = '0;
      for (int s = 0; s < N; s++) sread[s] = '0;
      repeat (3) @(negedge clk);
      check("rst_ds", slave_ds, 0);
      check("rst_ack_err", {master_ack, master_err}, 0);
      check("rst_read", master_read, 0);
      check("rst_err_addr", err_addr, 0);
      reset_n = 1;
      @(negedge clk);

      // 1: slave1 read, ack three cycles after its strobe
      start(32'h00F0_0004, 1, 16'h0, 2'b11);
      @(negedge clk); check("t1_ds", slave_ds, 4'b0010);
      check("t1_model_ds", exp_ds(), 4'b0010);
      @(negedge clk); @(negedge clk);
      sread[1] = 16'hBEEF; slave_ack = 4'b0010;
      @(negedge clk);
      check("t1_ack", master_ack, 1); check("t1_read", master_read, 16'hBEEF);
      check("t1_ds_clr", slave_ds, 0);
      slave_ack = '0;
      @(negedge clk); check("t1_ack_held", master_ack, 1);
      master_ds = 0;
      @(negedge clk); check("t1_ack_drop", master_ack, 0);

      // 2: overlapping slaves 2 and 3, lowest wins; slave3 ack is ignored
      start(32'h00F1_0010, 1, 16'h0, 2'b11);
      @(negedge clk); check("t2_ds", slave_ds, 4'b0100);
      sread[2] = 16'h1234; sread[3] = 16'hFFFF; slave_ack = 4'b1100;
      @(negedge clk);
      check("t2_ack", master_ack, 1); check("t2_read", master_read, 16'h1234);
      slave_ack = '0; master_ds = 0;
      @(negedge clk); check("t2_ack_drop", master_ack, 0);

      // 3: unmapped write
      start(32'h1234_5678, 0, 16'hA5A5, 2'b11);
      @(negedge clk);
      check("t3_err", master_err, 1); check("t3_err_addr", err_addr, 32'h1234_5678);
      check("t3_ds", slave_ds, 0); check("t3_ack", master_ack, 0);
      @(negedge clk); check("t3_ds2", slave_ds, 0); check("t3_err_held", master_err, 1);
      master_ds = 0;
      @(negedge clk); check("t3_err_drop", master_err, 0);

      // 4: slave0 never acks
      start(32'h0000_0100, 1, 16'h0, 2'b11);
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (master_err) break;
         if (slave_ds[0]) cnt++;
      end
      check("t4_ds_cycles", cnt, 8);
      check("t4_err", master_err, 1); check("t4_err_addr", err_addr, 32'h0000_0100);
      master_ds = 0;
      @(negedge clk); check("t4_err_drop", master_err, 0);

      // 5: spurious slave3 ack during slave0 access, then abort
      start(32'h0000_0200, 1, 16'h0, 2'b11);
      @(negedge clk); sread[3] = 16'hDEAD; slave_ack = 4'b1000;
      @(negedge clk); check("t5_no_ack", master_ack, 0); check("t5_ds", slave_ds, 4'b0001);
      @(negedge clk); check("t5_no_ack2", master_ack, 0); check("t5_ds2", slave_ds, 4'b0001);
      slave_ack = '0; master_ds = 0;
      @(negedge clk);
      check("t5_abort_ds", slave_ds, 0); check("t5_abort_ackerr", {master_ack, master_err}, 0);
      check("t5_read_kept", master_read, 16'h1234);

      // 6: reset mid-access, then a normal access
      start(32'h00F0_0008, 0, 16'h7777, 2'b01);
      @(negedge clk); check("t6_ds", slave_ds, 4'b0010);
      reset_n = 0; master_ds = 0;
      @(negedge clk);
      check("t6_rst_ds", slave_ds, 0); check("t6_rst_read", master_read, 0);
      check("t6_rst_err_addr", err_addr, 0); check("t6_rst_saddr", slave_addr, 0);
      check("t6_rst_swrite", slave_write, 0);
      reset_n = 1;
      @(negedge clk); start(32'h00F1_0020, 1, 16'h0, 2'b11);
      @(negedge clk); check("t6_ds_after", slave_ds, 4'b0100);
      sread[2] = 16'h5A5A; slave_ack = 4'b0100;
      @(negedge clk); check("t6_ack", master_ack, 1); check("t6_read", master_read, 16'h5A5A);
      slave_ack = '0; master_ds = 0;
      @(negedge clk);

      // Randomized traffic checked by the model every cycle
      active = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         for (int s = 0; s < N; s++) sread[s] = 16'($urandom());
         slave_ack = 4'($urandom()) & 4'($urandom());
         reset_n   = ($urandom_range(0, 299) != 0);
         if (active) begin
            if (master_ack || master_err) begin
               master_ds = 0; active = 0;
            end else if ($urandom_range(0, 39) == 0) begin
               master_ds = 0; active = 0; slave_ack = '0;
            end
         end else if ($urandom_range(0, 1) == 1) begin
            start(rand_addr(), 1'($urandom_range(0, 1)), 16'($urandom()), 2'($urandom()));
            active = 1;
         end
      end
      master_ds = 0; slave_ack = '0; reset_n = 1;
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
